// File: rtl/jk_excitation_driver_if.sv
// Target channel, J/K bank drive and self-check results for jk_excitation_driver.
// The master side is the target source and flip-flop bank. The slave side is the driver.
interface jk_excitation_driver_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             ff_en;
  logic [WIDTH-1:0] q_obs;
  logic             done;
  logic             mismatch;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output tgt_valid, tgt_q, q_obs,
    input  tgt_ready, j, k, ff_en, done, mismatch, err_cnt
  );

  modport slave (
    input  tgt_valid, tgt_q, q_obs,
    output tgt_ready, j, k, ff_en, done, mismatch, err_cnt
  );
endinterface

// File: rtl/jk_excitation_driver.sv
// Drives a JK flip-flop bank to target Q vectors and checks Q after settling; done 2+SETTLE_CYC cycles after accept.
// Backpressure: tgt_ready is high only in IDLE, giving one target per 3+SETTLE_CYC cycles.
module jk_excitation_driver #(
  parameter int WIDTH      = 4,
  parameter int SETTLE_CYC = 1,
  parameter int X_POLICY   = 0,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  jk_excitation_driver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  localparam int               CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic             X_FILL   = (X_POLICY != 0);

  state_t           state;
  logic [WIDTH-1:0] cur_q;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] j_nxt;
  logic [WIDTH-1:0] k_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic             q_differs;

  // Excitation table: a 0 bit only cares about J, a 1 bit only cares about K.
  always_comb begin
    j_nxt = '0;
    k_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cur_q[i]) begin
        j_nxt[i] = X_FILL;
        k_nxt[i] = ~bus.tgt_q[i];
      end else begin
        j_nxt[i] = bus.tgt_q[i];
        k_nxt[i] = X_FILL;
      end
    end
  end

  assign bus.tgt_ready = (state == IDLE);
  assign q_differs     = (bus.q_obs != exp_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur_q        <= '0;
      exp_q        <= '0;
      settle_cnt   <= '0;
      bus.j        <= '0;
      bus.k        <= '0;
      bus.ff_en    <= 1'b0;
      bus.done     <= 1'b0;
      bus.mismatch <= 1'b0;
      bus.err_cnt  <= '0;
    end else begin
      bus.j        <= '0;
      bus.k        <= '0;
      bus.ff_en    <= 1'b0;
      bus.done     <= 1'b0;
      bus.mismatch <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tgt_valid) begin
            exp_q     <= bus.tgt_q;
            bus.j     <= j_nxt;
            bus.k     <= k_nxt;
            bus.ff_en <= 1'b1;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          // The bank's Q is sampled on the SETTLE exit edge so the result is visible during CHECK.
          if (settle_cnt == CNT_LAST) begin
            bus.done     <= 1'b1;
            bus.mismatch <= q_differs;
            if (q_differs && (bus.err_cnt != ERR_MAX)) begin
              bus.err_cnt <= bus.err_cnt + 1'b1;
            end
            cur_q <= bus.q_obs;
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CHECK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: two drivers (X fill 0 and 1) each driving a 4-bit JK bank model, with hand-computed J/K and check results.
module tb_jk_excitation_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tgt_valid;
  logic [3:0] tgt_q;
  logic       stuck;
  logic [3:0] bank0;
  logic [3:0] bank1;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int acc_cyc[4];
  int n_acc;
  int n_done;
  int guard;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jk_excitation_driver_if #(.WIDTH(4), .ERR_W(8)) if0 ();
  jk_excitation_driver_if #(.WIDTH(4), .ERR_W(8)) if1 ();

  assign if0.tgt_valid = tgt_valid;
  assign if0.tgt_q     = tgt_q;
  assign if0.q_obs     = bank0;
  assign if1.tgt_valid = tgt_valid;
  assign if1.tgt_q     = tgt_q;
  assign if1.q_obs     = bank1;

  jk_excitation_driver #(.WIDTH(4), .SETTLE_CYC(1), .X_POLICY(0), .ERR_W(8)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  jk_excitation_driver #(.WIDTH(4), .SETTLE_CYC(1), .X_POLICY(1), .ERR_W(8)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  // JK characteristic: Q+ = J & ~Q | ~K & Q; bit 0 can be forced stuck at 0.
  function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] j, input logic [3:0] k,
                                         input logic st);
    logic [3:0] n;
    n = (j & ~q) | (~k & q);
    if (st) n[0] = 1'b0;
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank0 <= '0;
    else if (if0.ff_en) bank0 <= jk_next(bank0, if0.j, if0.k, stuck);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank1 <= '0;
    else if (if1.ff_en) bank1 <= jk_next(bank1, if1.j, if1.k, stuck);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!(if0.tgt_ready && if1.tgt_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check_eq("ready_timeout", 32'(if0.tgt_ready), 32'd1);
  endtask

  task automatic apply(input string tag, input logic [3:0] t,
                       input logic [3:0] j0, input logic [3:0] k0,
                       input logic [3:0] j1, input logic [3:0] k1,
                       input logic mis, input logic [7:0] err);
    wait_ready();
    tgt_valid = 1'b1;
    tgt_q     = t;
    @(negedge clk);
    tgt_valid = 1'b0;
    check_eq({tag, "_j0"}, 32'(if0.j), 32'(j0));
    check_eq({tag, "_k0"}, 32'(if0.k), 32'(k0));
    check_eq({tag, "_j1"}, 32'(if1.j), 32'(j1));
    check_eq({tag, "_k1"}, 32'(if1.k), 32'(k1));
    check_eq({tag, "_en"}, 32'({if0.ff_en, if1.ff_en}), 32'b11);
    @(negedge clk);
    check_eq({tag, "_settle"}, 32'({if0.ff_en, if0.done, if0.j, if0.k}), 32'd0);
    @(negedge clk);
    check_eq({tag, "_done"}, 32'({if0.done, if1.done}), 32'b11);
    check_eq({tag, "_mis0"}, 32'(if0.mismatch), 32'(mis));
    check_eq({tag, "_mis1"}, 32'(if1.mismatch), 32'(mis));
    check_eq({tag, "_err0"}, 32'(if0.err_cnt), 32'(err));
    check_eq({tag, "_err1"}, 32'(if1.err_cnt), 32'(err));
    @(negedge clk);
    check_eq({tag, "_rdy"}, 32'({if0.tgt_ready, if1.tgt_ready, if0.done}), 32'b110);
  endtask

  initial begin
    rst_n     = 1'b0;
    tgt_valid = 1'b0;
    tgt_q     = 4'b0000;
    stuck     = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_j0", 32'(if0.j), 32'd0);
    check_eq("rst_k0", 32'(if0.k), 32'd0);
    check_eq("rst_j1k1", 32'({if1.j, if1.k}), 32'd0);
    check_eq("rst_en", 32'({if0.ff_en, if1.ff_en}), 32'd0);
    check_eq("rst_done", 32'({if0.done, if0.mismatch}), 32'd0);
    check_eq("rst_err", 32'(if0.err_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_ready", 32'({if0.tgt_ready, if1.tgt_ready}), 32'b11);

    apply("set",   4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b1111, 1'b0, 8'd0);
    apply("mixed", 4'b0110, 4'b0100, 4'b1000, 4'b1110, 4'b1101, 1'b0, 8'd0);
    check_eq("mixed_bank0", 32'(bank0), 32'b0110);
    check_eq("mixed_bank1", 32'(bank1), 32'b0110);
    apply("same",  4'b0110, 4'b0000, 4'b0000, 4'b0110, 4'b1001, 1'b0, 8'd0);
    apply("clear", 4'b0000, 4'b0000, 4'b0110, 4'b0110, 4'b1111, 1'b0, 8'd0);

    stuck = 1'b1;
    apply("stuck1", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b1111, 1'b1, 8'd1);
    apply("stuck2", 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b1111, 1'b1, 8'd2);

    tgt_valid = 1'b1;
    tgt_q     = 4'b0001;
    n_done    = 0;
    guard     = 0;
    while (n_done < 298 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (if0.done) n_done++;
    end
    tgt_valid = 1'b0;
    check_eq("sat_done_cnt", 32'(n_done), 32'd298);
    repeat (2) @(negedge clk);
    check_eq("sat_err0", 32'(if0.err_cnt), 32'd255);
    check_eq("sat_err1", 32'(if1.err_cnt), 32'd255);
    stuck = 1'b0;

    wait_ready();
    tgt_valid = 1'b1;
    tgt_q     = 4'b1010;
    @(negedge clk);
    tgt_valid = 1'b0;
    check_eq("rs_drive_en", 32'(if0.ff_en), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("rs_err_async0", 32'(if0.err_cnt), 32'd0);
    check_eq("rs_err_async1", 32'(if1.err_cnt), 32'd0);
    @(negedge clk);
    check_eq("rs_no_done", 32'({if0.done, if1.done}), 32'd0);
    rst_n = 1'b1;
    n_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (if0.done || if1.done) n_done++;
    end
    check_eq("rs_done_after", 32'(n_done), 32'd0);
    check_eq("rs_ready", 32'(if0.tgt_ready), 32'd1);

    tgt_valid = 1'b1;
    tgt_q     = 4'b1010;
    @(negedge clk);
    tgt_valid = 1'b0;
    check_eq("rd_en", 32'(if0.ff_en), 32'd1);
    check_eq("rd_j0", 32'(if0.j), 32'b1010);
    rst_n = 1'b0;
    #1;
    check_eq("rd_en_async", 32'({if0.ff_en, if1.ff_en}), 32'd0);
    check_eq("rd_jk_async", 32'({if0.j, if1.j, if1.k}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    tgt_valid = 1'b1;
    tgt_q     = 4'b0011;
    n_acc     = 0;
    guard     = 0;
    while (n_acc < 4 && guard < 60) begin
      if (if0.tgt_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(negedge clk);
      guard++;
    end
    tgt_valid = 1'b0;
    check_eq("b2b_accepts", 32'(n_acc), 32'd4);
    for (int i = 1; i < 4; i++) begin
      check_eq("b2b_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd4);
    end
    repeat (4) @(negedge clk);
    check_eq("b2b_bank0", 32'(bank0), 32'b0011);
    check_eq("b2b_err", 32'(if0.err_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
